// File: rtl/sobel_edge_detect_pkg.sv
// Shared image-processing constants: default frame geometry, gradient width
// and the frame-tracking state encoding.
package sobel_edge_detect_pkg;

    localparam int IMAGE_WIDTH  = 1280;
    localparam int IMAGE_HEIGHT = 720;
    localparam int GRAD_W       = 11;
    localparam int COL_W        = 11;
    localparam int ROW_W        = 10;
    localparam int PIX_W        = 8;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Simple dual-port line RAM: one write port, one registered read port with
// read-before-write behaviour on an address collision. Contents are never reset.
module sobel_line_buffer #(
    parameter int DEPTH  = 1280,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/sobel_edge_detect.sv
// Sobel edge detector: 3x3 window fed by two line buffers, three-stage pipeline,
// binary edge output masked until the window holds pixels of the current frame.
module sobel_edge_detect #(
    parameter int          IMAGE_WIDTH  = sobel_edge_detect_pkg::IMAGE_WIDTH,
    parameter int          IMAGE_HEIGHT = sobel_edge_detect_pkg::IMAGE_HEIGHT,
    parameter logic [10:0] THRESHOLD    = 11'd200
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic [7:0] gray,
    input  logic       valid,
    input  logic       hsync,
    input  logic       vsync,
    output logic       valid_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       sobel
);
    import sobel_edge_detect_pkg::*;

    localparam int                 ADDR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [COL_W-1:0]   W_LIM  = COL_W'(IMAGE_WIDTH);
    localparam logic [ROW_W-1:0]   H_LIM  = ROW_W'(IMAGE_HEIGHT);

    function automatic logic signed [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                                      input logic [PIX_W-1:0] b,
                                                      input logic [PIX_W-1:0] c);
        return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    endfunction

    function automatic logic [GRAD_W-1:0] mag_abs(input logic signed [GRAD_W-1:0] v);
        return v[GRAD_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d, col_cur;
    logic [ROW_W-1:0]    row_q, row_d, row_cur;
    logic                seen_q, seen_d;
    logic                in_line, wr_en, rd_en, px_ok;
    logic [ADDR_W-1:0]   addr;
    logic [PIX_W-1:0]    rd_y1, rd_y2;

    logic [PIX_W-1:0]    gray_p0_q;
    logic                vld_p0_q, hs_p0_q, vs_p0_q, ok_p0_q, wb_we_p0_q;
    logic [ADDR_W-1:0]   wb_addr_p0_q;

    logic [PIX_W-1:0]    t0_q, m0_q, b0_q, t1_q, m1_q, b1_q;
    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_p1_q, gy_p1_q;
    logic                vld_p1_q, hs_p1_q, vs_p1_q, ok_p1_q;
    logic [GRAD_W-1:0]   mag;

    // hsync/vsync act before a pixel arriving in the same cycle
    always_comb begin
        col_cur = hsync ? '0 : col_q;
        row_cur = row_q;
        seen_d  = seen_q;
        if (vsync) begin
            row_cur = '0;
            seen_d  = 1'b0;
        end
        if (hsync) begin
            if (seen_d) begin
                row_cur = row_cur + ROW_W'(1);
            end
            seen_d = 1'b1;
        end
        row_d   = row_cur;
        col_d   = col_cur + {{(COL_W-1){1'b0}}, valid};
        state_d = state_q;
        if (vsync) begin
            state_d = ACTIVE;
        end else if (state_q == ACTIVE && hsync && row_cur == H_LIM) begin
            state_d = WAIT_FRAME;
        end
        in_line = (col_cur < W_LIM);
        rd_en   = valid && in_line;
        wr_en   = rd_en && (state_q == ACTIVE);
        px_ok   = wr_en && (col_cur >= COL_W'(2)) && (row_cur >= ROW_W'(2)) && (row_cur < H_LIM);
        addr    = col_cur[ADDR_W-1:0];
    end

    sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_buf_y1 (
        .clk_i   (clk_pixel),
        .we_i    (wr_en),
        .waddr_i (addr),
        .wdata_i (gray),
        .re_i    (rd_en),
        .raddr_i (addr),
        .rdata_o (rd_y1)
    );

    // Row y-1 word moves into the y-2 buffer once its read data is back
    sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_buf_y2 (
        .clk_i   (clk_pixel),
        .we_i    (wb_we_p0_q),
        .waddr_i (wb_addr_p0_q),
        .wdata_i (rd_y1),
        .re_i    (rd_en),
        .raddr_i (addr),
        .rdata_o (rd_y2)
    );

    // Stage 0: counters, frame state, line-buffer access
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_FRAME;
            col_q        <= '0;
            row_q        <= '0;
            seen_q       <= 1'b0;
            gray_p0_q    <= '0;
            vld_p0_q     <= 1'b0;
            hs_p0_q      <= 1'b0;
            vs_p0_q      <= 1'b0;
            ok_p0_q      <= 1'b0;
            wb_we_p0_q   <= 1'b0;
            wb_addr_p0_q <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            seen_q       <= seen_d;
            gray_p0_q    <= gray;
            vld_p0_q     <= valid;
            hs_p0_q      <= hsync;
            vs_p0_q      <= vsync;
            ok_p0_q      <= px_ok;
            wb_we_p0_q   <= wr_en;
            wb_addr_p0_q <= addr;
        end
    end

    // Right column is {row y-2, row y-1, current pixel}
    assign gx_d = wsum(rd_y2, rd_y1, gray_p0_q) - wsum(t0_q, m0_q, b0_q);
    assign gy_d = wsum(b0_q, b1_q, gray_p0_q) - wsum(t0_q, t1_q, rd_y2);

    // Stage 1: window shift and gradients
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            {t0_q, m0_q, b0_q, t1_q, m1_q, b1_q} <= '0;
            gx_p1_q  <= '0;
            gy_p1_q  <= '0;
            vld_p1_q <= 1'b0;
            hs_p1_q  <= 1'b0;
            vs_p1_q  <= 1'b0;
            ok_p1_q  <= 1'b0;
        end else begin
            if (vld_p0_q) begin
                {t0_q, m0_q, b0_q} <= {t1_q, m1_q, b1_q};
                {t1_q, m1_q, b1_q} <= {rd_y2, rd_y1, gray_p0_q};
            end
            gx_p1_q  <= gx_d;
            gy_p1_q  <= gy_d;
            vld_p1_q <= vld_p0_q;
            hs_p1_q  <= hs_p0_q;
            vs_p1_q  <= vs_p0_q;
            ok_p1_q  <= ok_p0_q;
        end
    end

    assign mag = mag_abs(gx_p1_q) + mag_abs(gy_p1_q);

    // Stage 2: magnitude compare and output registers
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            sobel     <= 1'b0;
        end else begin
            valid_out <= vld_p1_q;
            hsync_out <= hs_p1_q;
            vsync_out <= vs_p1_q;
            sobel     <= ok_p1_q && (mag >= THRESHOLD);
        end
    end

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Self-checking bench for sobel_edge_detect on a reduced 16x8 frame with a
// behavioural Sobel model computed directly from the driven image.
module tb_sobel_edge_detect;

    localparam int W    = 16;
    localparam int H    = 8;
    localparam int TH   = 200;
    localparam int XMAX = W + 20;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gray = 8'd0;
    logic       valid = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       valid_out, hsync_out, vsync_out, sobel;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic obs_v [MAXC];
    logic obs_h [MAXC];
    logic obs_vs[MAXC];
    logic obs_s [MAXC];

    bit [7:0] img  [H][XMAX];
    int       len  [H];
    int       pcyc [H][XMAX];
    int       vs_cyc, end_cyc, rst_cyc;

    sobel_edge_detect #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .THRESHOLD   (11'd200)
    ) dut (
        .clk_pixel(clk),
        .rst_n    (rst_n),
        .gray     (gray),
        .valid    (valid),
        .hsync    (hsync),
        .vsync    (vsync),
        .valid_out(valid_out),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .sobel    (sobel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            obs_v[cyc]  = valid_out;
            obs_h[cyc]  = hsync_out;
            obs_vs[cyc] = vsync_out;
            obs_s[cyc]  = sobel;
        end
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Edge value of the 3x3 neighbourhood centred at (x-1, y-1)
    function automatic bit model_sobel(input int x, input int y);
        int p[3][3];
        int gx, gy;
        if (x < 2 || y < 2 || x >= W || y >= H) return 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = int'(img[y-2+r][x-2+c]);
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        return (iabs(gx) + iabs(gy)) >= TH;
    endfunction

    function automatic logic get_v(input int c);
        return (c < MAXC) ? obs_v[c] : 1'bx;
    endfunction

    function automatic logic get_s(input int c);
        return (c < MAXC) ? obs_s[c] : 1'bx;
    endfunction

    task automatic drive(input bit v, input bit h, input bit vs, input bit [7:0] g);
        @(posedge clk);
        #1;
        valid = v;
        hsync = h;
        vsync = vs;
        gray  = g;
    endtask

    task automatic fill_random();
        for (int y = 0; y < H; y++) begin
            len[y] = W;
            for (int x = 0; x < XMAX; x++) img[y][x] = 8'($urandom);
        end
    endtask

    task automatic send_frame(input bit merge, input int rrow);
        rst_cyc = -1;
        drive(1'b0, 1'b0, 1'b1, 8'd0);
        vs_cyc = cyc;
        for (int y = 0; y < H; y++) begin
            if (!merge) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
            for (int x = 0; x < len[y]; x++) begin
                if (y == rrow && x == W/2) begin
                    @(posedge clk);
                    #1;
                    rst_n = 1'b0;
                    valid = 1'b0;
                    hsync = 1'b0;
                    vsync = 1'b0;
                    rst_cyc = cyc;
                    repeat (2) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                end
                if ($urandom_range(0, 4) == 0) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
                drive(1'b1, merge && (x == 0), 1'b0, img[y][x]);
                pcyc[y][x] = cyc;
            end
        end
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        end_cyc = cyc;
        repeat (5) drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            @(negedge clk);
            n_cmp++;
            if ({valid_out, hsync_out, vsync_out, sobel} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_outputs: {valid_out,hsync_out,vsync_out,sobel}=%b, expected 0000",
                         {valid_out, hsync_out, vsync_out, sobel});
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_strobes();
        int c[3];
        logic got;
        for (int k = 0; k < 3; k++) begin
            drive(k == 0, k == 1, k == 2, 8'd77);
            c[k] = cyc;
            repeat (6) drive(1'b0, 1'b0, 1'b0, 8'd0);
        end
        for (int k = 0; k < 3; k++) begin
            for (int d = 2; d <= 4; d++) begin
                case (k)
                    0:       got = obs_v[c[k]+d];
                    1:       got = obs_h[c[k]+d];
                    default: got = obs_vs[c[k]+d];
                endcase
                n_cmp++;
                if (got !== (d == 3)) begin
                    n_err++;
                    $display("FAIL strobe_delay ch=%0d offset=%0d: got %b, expected %b", k, d, got, d == 3);
                end
            end
        end
    endtask

    task automatic test_uniform();
        int cnt;
        logic es;
        for (int y = 0; y < H; y++) begin
            len[y] = W;
            for (int x = 0; x < XMAX; x++) img[y][x] = 8'd128;
        end
        send_frame(1'b0, -1);
        cnt = 0;
        for (int c = vs_cyc; c <= end_cyc + 3; c++) if (obs_v[c] === 1'b1) cnt++;
        n_cmp++;
        if (cnt != W*H) begin
            n_err++;
            $display("FAIL uniform_count: %0d valid_out pulses, expected %0d", cnt, W*H);
        end
        n_cmp++;
        if (obs_vs[vs_cyc+3] !== 1'b1) begin
            n_err++;
            $display("FAIL uniform_vsync_out: got %b, expected 1", obs_vs[vs_cyc+3]);
        end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                es = get_s(pcyc[y][x] + 3);
                n_cmp++;
                if (es !== 1'b0) begin
                    n_err++;
                    $display("FAIL uniform_px(%0d,%0d): sobel=%b, expected 0", x, y, es);
                end
            end
    endtask

    task automatic test_random_frames();
        int c;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(f == 1, -1);
            for (int y = 0; y < H; y++)
                for (int x = 0; x < len[y]; x++) begin
                    c = pcyc[y][x] + 3;
                    n_cmp++;
                    if (get_v(c) !== 1'b1 || get_s(c) !== model_sobel(x, y)) begin
                        n_err++;
                        $display("FAIL random_f%0d_px(%0d,%0d): valid_out=%b sobel=%b, expected 1 %b",
                                 f, x, y, get_v(c), get_s(c), model_sobel(x, y));
                    end
                end
        end
    endtask

    task automatic test_vertical_step();
        int c;
        bit es;
        for (int y = 0; y < H; y++) begin
            len[y] = W;
            for (int x = 0; x < XMAX; x++) img[y][x] = (x < W/2) ? 8'd0 : 8'd255;
        end
        send_frame(1'b0, -1);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                c  = pcyc[y][x] + 3;
                es = (y >= 2) && (x == W/2 || x == W/2 + 1);
                n_cmp++;
                if (get_s(c) !== es) begin
                    n_err++;
                    $display("FAIL vstep_px(%0d,%0d): sobel=%b, expected %b", x, y, get_s(c), es);
                end
            end
    endtask

    task automatic test_threshold();
        int c, a, d;
        bit es;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 50 : 49;
            a = $urandom_range(0, 200);
            for (int y = 0; y < H; y++) begin
                len[y] = W;
                for (int x = 0; x < XMAX; x++) img[y][x] = 8'((y < H/2) ? a : a + d);
            end
            send_frame(1'b0, -1);
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    c  = pcyc[y][x] + 3;
                    es = (d == 50) && (x >= 2) && (y == H/2 || y == H/2 + 1);
                    n_cmp++;
                    if (get_s(c) !== es) begin
                        n_err++;
                        $display("FAIL hstep_d%0d_px(%0d,%0d): sobel=%b, expected %b", d, x, y, get_s(c), es);
                    end
                end
        end
    endtask

    task automatic test_long_line();
        int c;
        bit es;
        fill_random();
        len[3] = W + 20;
        send_frame(1'b0, -1);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < len[y]; x++) begin
                c  = pcyc[y][x] + 3;
                es = (x >= W) ? 1'b0 : model_sobel(x, y);
                n_cmp++;
                if (get_v(c) !== 1'b1 || get_s(c) !== es) begin
                    n_err++;
                    $display("FAIL longline_px(%0d,%0d): valid_out=%b sobel=%b, expected 1 %b",
                             x, y, get_v(c), get_s(c), es);
                end
            end
    endtask

    task automatic test_reset_midframe();
        int c, rc;
        bit ev, es;
        for (int f = 0; f < 2; f++) begin
            fill_random();
            send_frame(1'b0, (f == 0) ? H/2 : -1);
            rc = rst_cyc;
            if (f == 0) begin
                for (int k = 0; k < 3; k++) begin
                    n_cmp++;
                    if ({obs_v[rc+k], obs_h[rc+k], obs_vs[rc+k], obs_s[rc+k]} !== 4'b0000) begin
                        n_err++;
                        $display("FAIL midreset_outputs+%0d: got %b, expected 0000", k,
                                 {obs_v[rc+k], obs_h[rc+k], obs_vs[rc+k], obs_s[rc+k]});
                    end
                end
            end
            for (int y = 0; y < H; y++)
                for (int x = 0; x < len[y]; x++) begin
                    c = pcyc[y][x] + 3;
                    if (rc >= 0 && pcyc[y][x] >= rc) begin
                        ev = 1'b1;
                        es = 1'b0;
                    end else if (rc >= 0 && c >= rc) begin
                        ev = 1'b0;
                        es = 1'b0;
                    end else begin
                        ev = 1'b1;
                        es = model_sobel(x, y);
                    end
                    n_cmp++;
                    if (get_v(c) !== ev || get_s(c) !== es) begin
                        n_err++;
                        $display("FAIL midreset_f%0d_px(%0d,%0d): valid_out=%b sobel=%b, expected %b %b",
                                 f, x, y, get_v(c), get_s(c), ev, es);
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_strobes();
        test_uniform();
        test_random_frames();
        test_vertical_step();
        test_threshold();
        test_long_line();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
